// File: rtl/bist_lfsr_pkg.sv
// Shared types and defaults for the BIST LFSR engine (PRBS generator / MISR).
package bist_lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } fsm_t;

    localparam logic MODE_GEN  = 1'b0;
    localparam logic MODE_MISR = 1'b1;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS = 16'h8058;

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci-style LFSR shift, optionally folding an input word in (MISR absorb).
module lfsr_step #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic [WIDTH-1:0]     state,
    input  logic [WIDTH-1:0]     taps,
    input  logic [OUT_WIDTH-1:0] data,
    input  logic                 data_en,
    output logic [WIDTH-1:0]     next_state
);

    logic             fb;
    logic [WIDTH-1:0] data_ext;

    assign fb         = ^(state & taps);
    assign data_ext   = data_en ? WIDTH'(data) : '0;
    assign next_state = {state[WIDTH-2:0], fb} ^ data_ext;

endmodule

// File: rtl/bist_lfsr_engine.sv
// LFSR engine for the UART BIST path: PRBS word generator with valid/ready output,
// or MISR signature compactor, with loadable seed/taps and zero-state recovery.
module bist_lfsr_engine
    import bist_lfsr_pkg::*;
#(
    parameter int unsigned    WIDTH     = 16,
    parameter int unsigned    OUT_WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEFAULT_TAPS),
    parameter int unsigned    STEPS     = 8,
    parameter int unsigned    CNT_WIDTH = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Mode,
    input  logic                 i_Load,
    input  logic [WIDTH-1:0]     i_Seed,
    input  logic [WIDTH-1:0]     i_Taps,
    input  logic                 i_Enable,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic [OUT_WIDTH-1:0] o_Data,
    input  logic                 i_Data_Valid,
    input  logic [OUT_WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0]     o_State,
    output logic [CNT_WIDTH-1:0] o_Word_Count,
    output logic                 o_Lockup,
    output logic                 o_Busy
);

    localparam int unsigned       STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    fsm_t                 fsm_q, fsm_d;
    logic [WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-1:0]     taps_q, taps_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 lockup_q, lockup_d;
    logic                 busy_q;

    logic                 absorb;
    logic                 zero_state;
    logic [WIDTH-1:0]     step_out;
    logic [WIDTH-1:0]     gen_next;

    // MISR absorb only happens from IDLE in signature mode; SHIFT never folds data in
    assign absorb     = (fsm_q == IDLE) && (i_Mode == MODE_MISR) && i_Data_Valid;
    assign zero_state = (lfsr_q == '0);

    lfsr_step #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_step (
        .state      (lfsr_q),
        .taps       (taps_q),
        .data       (i_Data),
        .data_en    (absorb),
        .next_state (step_out)
    );

    // Generate-mode step with lock-up recovery to the fixed SEED
    assign gen_next = zero_state ? SEED : step_out;

    always_comb begin
        fsm_d    = fsm_q;
        lfsr_d   = lfsr_q;
        taps_d   = taps_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        valid_d  = valid_q;
        data_d   = data_q;
        lockup_d = 1'b0;

        if (i_Load) begin
            lfsr_d  = i_Seed;
            taps_d  = i_Taps;
            cnt_d   = '0;
            step_d  = '0;
            valid_d = 1'b0;
            fsm_d   = IDLE;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (i_Mode == MODE_GEN) begin
                        if (i_Enable) begin
                            fsm_d  = SHIFT;
                            step_d = '0;
                        end
                    end else if (i_Data_Valid) begin
                        lfsr_d = step_out;
                        cnt_d  = cnt_q + CNT_WIDTH'(1);
                    end
                end

                SHIFT: begin
                    lfsr_d   = gen_next;
                    lockup_d = zero_state;
                    if (step_q == LAST_STEP) begin
                        fsm_d   = HOLD;
                        step_d  = '0;
                        valid_d = 1'b1;
                        data_d  = gen_next[OUT_WIDTH-1:0];
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end

                HOLD: begin
                    if (i_Ready) begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        valid_d = 1'b0;
                        step_d  = '0;
                        fsm_d   = i_Enable ? SHIFT : IDLE;
                    end
                end

                default: begin
                    fsm_d   = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            fsm_q    <= IDLE;
            lfsr_q   <= SEED;
            taps_q   <= TAPS;
            cnt_q    <= '0;
            step_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            lockup_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            taps_q   <= taps_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            lockup_q <= lockup_d;
            busy_q   <= (fsm_d != IDLE);
        end
    end

    assign o_Valid      = valid_q;
    assign o_Data       = data_q;
    assign o_State      = lfsr_q;
    assign o_Word_Count = cnt_q;
    assign o_Lockup     = lockup_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_bist_lfsr_engine.sv
// Randomized self-checking bench for bist_lfsr_engine against a word-level behavioural model.
module tb_bist_lfsr_engine;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned OUT_WIDTH = 8;
    localparam int unsigned STEPS     = 8;
    localparam int unsigned CNT_WIDTH = 16;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam logic [15:0] TAPS      = 16'h8058;

    logic                 clk = 1'b0;
    logic                 i_Reset;
    logic                 i_Mode;
    logic                 i_Load;
    logic [WIDTH-1:0]     i_Seed;
    logic [WIDTH-1:0]     i_Taps;
    logic                 i_Enable;
    logic                 o_Valid;
    logic                 i_Ready;
    logic [OUT_WIDTH-1:0] o_Data;
    logic                 i_Data_Valid;
    logic [OUT_WIDTH-1:0] i_Data;
    logic [WIDTH-1:0]     o_State;
    logic [CNT_WIDTH-1:0] o_Word_Count;
    logic                 o_Lockup;
    logic                 o_Busy;

    bist_lfsr_engine dut (
        .i_Clock      (clk),
        .i_Reset      (i_Reset),
        .i_Mode       (i_Mode),
        .i_Load       (i_Load),
        .i_Seed       (i_Seed),
        .i_Taps       (i_Taps),
        .i_Enable     (i_Enable),
        .o_Valid      (o_Valid),
        .i_Ready      (i_Ready),
        .o_Data       (o_Data),
        .i_Data_Valid (i_Data_Valid),
        .i_Data       (i_Data),
        .o_State      (o_State),
        .o_Word_Count (o_Word_Count),
        .o_Lockup     (o_Lockup),
        .o_Busy       (o_Busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural state only, no cycle-level FSM
    logic [15:0] m_state;
    logic [15:0] m_taps;
    logic [15:0] m_cnt;
    logic [7:0]  m_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift left by one (multiply by two) and append the parity of the tapped bits
    function automatic logic [15:0] model_shift(input logic [15:0] s, input logic [15:0] t);
        int unsigned par;
        par = int'($countones(s & t)) % 2;
        return 16'((32'(s) * 2 + par) % 65536);
    endfunction

    task automatic do_load(input logic [15:0] seed, input logic [15:0] taps);
        i_Load = 1'b1; i_Seed = seed; i_Taps = taps;
        i_Enable = 1'b0; i_Data_Valid = 1'b0; i_Ready = 1'b0;
        tick();
        i_Load = 1'b0;
        m_state = seed; m_taps = taps; m_cnt = 16'h0;
        chk("load_state", 32'(o_State), 32'(m_state));
        chk("load_cnt",   32'(o_Word_Count), 32'(0));
        chk("load_valid", 32'(o_Valid), 32'(0));
        chk("load_busy",  32'(o_Busy), 32'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            i_Mode = 1'b0; i_Enable = 1'b0;
            i_Data_Valid = 1'($urandom % 2); i_Data = 8'($urandom);
            tick();
            chk("idle_state", 32'(o_State), 32'(m_state));
            chk("idle_cnt",   32'(o_Word_Count), 32'(m_cnt));
            chk("idle_valid", 32'(o_Valid), 32'(0));
            chk("idle_busy",  32'(o_Busy), 32'(0));
        end
        i_Data_Valid = 1'b0;
    endtask

    task automatic start_word();
        i_Mode = 1'b0; i_Enable = 1'b1;
        tick();
        chk("go_busy",  32'(o_Busy), 32'(1));
        chk("go_state", 32'(o_State), 32'(m_state));
        chk("go_valid", 32'(o_Valid), 32'(0));
    endtask

    // Steps first..first+n-1 of a word; mode/enable/data noise must not disturb it
    task automatic steps(input int first, input int n);
        logic exp_lk;
        for (int s = first; s < first + n; s++) begin
            i_Mode = 1'($urandom % 2); i_Enable = 1'($urandom % 2);
            i_Data_Valid = 1'($urandom % 2); i_Data = 8'($urandom);
            tick();
            if (m_state == 16'h0) begin
                m_state = SEED; exp_lk = 1'b1;
            end else begin
                m_state = model_shift(m_state, m_taps); exp_lk = 1'b0;
            end
            chk("step_state",  32'(o_State), 32'(m_state));
            chk("step_lockup", 32'(o_Lockup), 32'(exp_lk));
            chk("step_valid",  32'(o_Valid), 32'(s == STEPS - 1));
        end
    endtask

    task automatic gen_word(input bit from_idle, input int hold, input bit last);
        if (from_idle) start_word();
        i_Ready = (hold == 0);
        steps(0, STEPS);
        m_word = m_state[7:0];
        chk("word_data", 32'(o_Data), 32'(m_word));
        for (int h = 0; h < hold; h++) begin
            i_Enable = 1'($urandom % 2); i_Mode = 1'($urandom % 2);
            i_Data_Valid = 1'($urandom % 2);
            tick();
            chk("hold_data",   32'(o_Data), 32'(m_word));
            chk("hold_state",  32'(o_State), 32'(m_state));
            chk("hold_valid",  32'(o_Valid), 32'(1));
            chk("hold_cnt",    32'(o_Word_Count), 32'(m_cnt));
            chk("hold_lockup", 32'(o_Lockup), 32'(0));
        end
        i_Ready = 1'b1; i_Enable = !last;
        tick();
        m_cnt = m_cnt + 16'h1;
        chk("hs_cnt",   32'(o_Word_Count), 32'(m_cnt));
        chk("hs_valid", 32'(o_Valid), 32'(0));
        chk("hs_busy",  32'(o_Busy), 32'(!last));
        chk("hs_state", 32'(o_State), 32'(m_state));
        i_Mode = 1'b0; i_Data_Valid = 1'b0; i_Ready = 1'b0;
    endtask

    task automatic misr_burst(input int n);
        logic       dv;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            i_Mode = 1'b1; i_Enable = 1'($urandom % 2);
            dv = 1'($urandom % 2); d = 8'($urandom);
            i_Data_Valid = dv; i_Data = d;
            tick();
            if (dv) begin
                m_state = model_shift(m_state, m_taps) ^ {8'h00, d};
                m_cnt   = m_cnt + 16'h1;
            end
            chk("misr_state",  32'(o_State), 32'(m_state));
            chk("misr_cnt",    32'(o_Word_Count), 32'(m_cnt));
            chk("misr_valid",  32'(o_Valid), 32'(0));
            chk("misr_lockup", 32'(o_Lockup), 32'(0));
            chk("misr_busy",   32'(o_Busy), 32'(0));
        end
        i_Mode = 1'b0; i_Data_Valid = 1'b0; i_Enable = 1'b0;
    endtask

    initial begin
        i_Reset = 1'b1; i_Mode = 1'b0; i_Load = 1'b0; i_Seed = '0; i_Taps = '0;
        i_Enable = 1'b0; i_Ready = 1'b0; i_Data_Valid = 1'b0; i_Data = '0;
        tick();
        tick();
        chk("rst_state",  32'(o_State), 32'(SEED));
        chk("rst_valid",  32'(o_Valid), 32'(0));
        chk("rst_data",   32'(o_Data), 32'(0));
        chk("rst_cnt",    32'(o_Word_Count), 32'(0));
        chk("rst_lockup", 32'(o_Lockup), 32'(0));
        chk("rst_busy",   32'(o_Busy), 32'(0));
        i_Reset = 1'b0;
        m_state = SEED; m_taps = TAPS; m_cnt = 16'h0;
        idle_cycles(3);

        // Known PRBS word from seed 1, immediate accept
        do_load(16'h0001, TAPS);
        gen_word(1'b1, 0, 1'b1);
        chk("tp1_data",  32'(o_Data), 32'(8'h1B));
        chk("tp1_state", 32'(o_State), 32'(16'h011B));
        chk("tp1_cnt",   32'(o_Word_Count), 32'(1));

        // Same word with consumer back-pressure
        do_load(16'h0001, TAPS);
        gen_word(1'b1, 5, 1'b1);
        chk("tp2_data", 32'(o_Data), 32'(8'h1B));

        // Signature from zero seed
        do_load(16'h0000, TAPS);
        i_Mode = 1'b1; i_Data_Valid = 1'b1; i_Data = 8'hA5;
        tick();
        chk("tp3_sig1", 32'(o_State), 32'(16'h00A5));
        i_Data = 8'h01;
        tick();
        chk("tp3_sig2",   32'(o_State), 32'(16'h014B));
        chk("tp3_cnt",    32'(o_Word_Count), 32'(2));
        chk("tp3_valid",  32'(o_Valid), 32'(0));
        chk("tp3_lockup", 32'(o_Lockup), 32'(0));
        i_Mode = 1'b0; i_Data_Valid = 1'b0;
        m_state = 16'h014B; m_cnt = 16'h2;

        // Zero-state recovery in generate mode
        do_load(16'h0000, TAPS);
        start_word();
        i_Ready = 1'b0;
        steps(0, 1);
        chk("tp4_state",  32'(o_State), 32'(SEED));
        chk("tp4_lockup", 32'(o_Lockup), 32'(1));
        steps(1, 1);
        chk("tp4_pulse",  32'(o_Lockup), 32'(0));
        steps(2, STEPS - 2);
        chk("tp4_valid", 32'(o_Valid), 32'(1));

        // Abort mid-SHIFT, then abort in HOLD; aborted words never appear
        do_load(16'h1357, TAPS);
        start_word();
        steps(0, 4);
        do_load(16'h2468, 16'hB400);
        idle_cycles(STEPS + 2);
        start_word();
        i_Ready = 1'b0;
        steps(0, STEPS);
        chk("tp5_hold_valid", 32'(o_Valid), 32'(1));
        do_load(16'h0F0F, TAPS);
        idle_cycles(STEPS + 2);

        // Reset while HOLD with ready high
        do_load(16'h1234, 16'h0001);
        start_word();
        i_Ready = 1'b0;
        steps(0, STEPS);
        i_Reset = 1'b1; i_Ready = 1'b1; i_Enable = 1'b1;
        tick();
        i_Reset = 1'b0; i_Ready = 1'b0; i_Enable = 1'b0;
        m_state = SEED; m_taps = TAPS; m_cnt = 16'h0;
        chk("tp6_state", 32'(o_State), 32'(SEED));
        chk("tp6_valid", 32'(o_Valid), 32'(0));
        chk("tp6_busy",  32'(o_Busy), 32'(0));
        chk("tp6_cnt",   32'(o_Word_Count), 32'(0));
        gen_word(1'b1, 1, 1'b1);

        // Randomized sessions
        for (int it = 0; it < 40; it++) begin
            logic [15:0] seed, taps;
            int nw;
            seed = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
            case ($urandom % 8)
                0, 1:    taps = TAPS;
                2:       taps = 16'h0;
                default: taps = 16'($urandom);
            endcase
            do_load(seed, taps);
            if ($urandom % 2 == 0) begin
                nw = 1 + int'($urandom % 3);
                for (int w = 0; w < nw; w++)
                    gen_word(w == 0, int'($urandom % 4), w == nw - 1);
            end else begin
                misr_burst(5 + int'($urandom % 16));
            end
            idle_cycles(1 + int'($urandom % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
